// File: rtl/serial_arbiter_pkg.sv
// Shared definitions for the serial arbiter, its transmitter and the bench:
// FSM state encoding, default byte width and the round-robin pointer step.
package serial_arbiter_pkg;

   localparam int DEFAULT_W = 8;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_START     = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

   // Pointer moves just past the winner, wrapping from n-1 back to 0.
   function automatic int rr_next(input int winner, input int n);
      return (winner == n - 1) ? 0 : winner + 1;
   endfunction

endpackage

// File: rtl/serial_arbiter_rr_pick.sv
// Combinational round-robin picker: searches ptr, ptr+1, ... modulo N and
// returns the first requester with req high.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [PW-1:0] winner_o,
   output logic          valid_o
);

   int idx;

   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr_i) + i) % N;
         if (!valid_o && req_i[idx]) begin
            valid_o  = 1'b1;
            winner_o = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/serial_arbiter.sv
// Round-robin arbiter feeding N byte requesters into one serial transmitter.
// Handshake: req[i] is held with its byte until a one-cycle ack[i]; tx_start is a one-cycle strobe and tx_busy tracks the frame.
module serial_arbiter
   import serial_arbiter_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = DEFAULT_W,
   localparam int PW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] req_data,
   output logic [N-1:0]   ack,
   output logic           tx_start,
   output logic [W-1:0]   tx_data,
   input  logic           tx_busy,
   output logic [PW-1:0]  grant_id,
   output logic           busy,
   output logic [1:0]     dbg_state_o,
   output logic [PW-1:0]  dbg_ptr_o
);

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          tx_start_q, tx_start_d;
   logic [N-1:0]  ack_q, ack_d;
   logic [W-1:0]  tx_data_q, tx_data_d;
   logic [PW-1:0] grant_id_q, grant_id_d;
   logic [PW-1:0] winner;
   logic          pick_valid;

   rr_pick #(.N(N), .PW(PW)) u_rr_pick (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .winner_o (winner),
      .valid_o  (pick_valid)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      tx_start_d = 1'b0;
      ack_d      = '0;
      tx_data_d  = tx_data_q;
      grant_id_d = grant_id_q;
      case (state_q)
         ST_IDLE: begin
            // External transmitter activity blocks grants without error.
            if (!tx_busy && pick_valid) begin
               state_d    = ST_START;
               tx_start_d = 1'b1;
               ack_d      = {{(N-1){1'b0}}, 1'b1} << winner;
               tx_data_d  = req_data[int'(winner)*W +: W];
               grant_id_d = winner;
               ptr_d      = PW'(rr_next(int'(winner), N));
            end
         end
         ST_START:     state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (tx_busy)  state_d = ST_WAIT_IDLE;
         ST_WAIT_IDLE: if (!tx_busy) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         tx_start_q <= 1'b0;
         ack_q      <= '0;
         tx_data_q  <= '0;
         grant_id_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         tx_start_q <= tx_start_d;
         ack_q      <= ack_d;
         tx_data_q  <= tx_data_d;
         grant_id_q <= grant_id_d;
      end
   end

   assign ack         = ack_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_id_q;
   assign busy        = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;
   assign dbg_ptr_o   = ptr_q;

endmodule
